// File: rtl/mem_region_router.sv
// Routes load/store memory requests to one of several targets by address range and
// returns responses strictly in issue order through a small tag FIFO.
module mem_region_router #(
    parameter int          NUM_TARGETS     = 4,
    parameter logic [31:0] REGION_L [NUM_TARGETS] = '{32'h80000000, 32'h60000000, 32'h70000000, 32'h00000000},
    parameter logic [31:0] REGION_H [NUM_TARGETS] = '{32'h8FFFFFFF, 32'h6FFFFFFF, 32'h7FFFFFFF, 32'h0000FFFF},
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [31:0]                       req_addr,
    input  logic                              req_we,
    input  logic [31:0]                       req_wdata,
    input  logic [3:0]                        req_be,
    output logic [NUM_TARGETS-1:0]            tgt_valid,
    input  logic [NUM_TARGETS-1:0]            tgt_ready,
    output logic [31:0]                       tgt_addr,
    output logic                              tgt_we,
    output logic [31:0]                       tgt_wdata,
    output logic [3:0]                        tgt_be,
    input  logic [NUM_TARGETS-1:0]            tgt_rvalid,
    input  logic [NUM_TARGETS*32-1:0]         tgt_rdata,
    output logic [NUM_TARGETS-1:0]            tgt_rready,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [31:0]                       rsp_data,
    output logic                              rsp_err,
    output logic [$clog2(MAX_OUTSTANDING):0]  outstanding
);
    localparam int IDXW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
    localparam int PTRW = $clog2(MAX_OUTSTANDING);
    localparam int CNTW = PTRW + 1;

    logic [NUM_TARGETS-1:0] w_hit;
    logic [IDXW-1:0]        w_sel;
    logic                   w_unmapped;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_headErr;
    logic [IDXW-1:0]        w_headIdx;

    logic [PTRW-1:0]        r_wrPtr;
    logic [PTRW-1:0]        r_rdPtr;
    logic [CNTW-1:0]        r_count;
    logic                   r_errMem [MAX_OUTSTANDING];
    logic [IDXW-1:0]        r_idxMem [MAX_OUTSTANDING];

    // Unsigned L <= addr <= H written as one modular subtraction so a zero lower bound
    // does not turn into an always-true comparison; descending loop makes index 0 win.
    always_comb begin
        w_hit = '0;
        w_sel = '0;
        for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
            w_hit[i] = (req_addr - REGION_L[i]) <= (REGION_H[i] - REGION_L[i]);
            if (w_hit[i]) begin
                w_sel = IDXW'(i);
            end
        end
    end

    assign w_unmapped = ~|w_hit;
    assign w_full     = (r_count == CNTW'(MAX_OUTSTANDING));
    assign w_empty    = (r_count == '0);

    assign tgt_addr  = req_addr;
    assign tgt_we    = req_we;
    assign tgt_wdata = req_wdata;
    assign tgt_be    = req_be;

    always_comb begin
        tgt_valid = '0;
        req_ready = 1'b0;
        if (!rst && !w_full) begin
            req_ready = w_unmapped || tgt_ready[w_sel];
            if (req_valid && !w_unmapped) begin
                tgt_valid[w_sel] = 1'b1;
            end
        end
    end

    assign w_headErr = r_errMem[r_rdPtr];
    assign w_headIdx = r_idxMem[r_rdPtr];

    // Only the head entry may talk to the requester; other targets stall with rready low.
    always_comb begin
        rsp_valid  = 1'b0;
        rsp_data   = '0;
        rsp_err    = 1'b0;
        tgt_rready = '0;
        if (!w_empty) begin
            if (w_headErr) begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
            end else begin
                rsp_valid             = tgt_rvalid[w_headIdx];
                rsp_data              = tgt_rdata[{w_headIdx, 5'd0} +: 32];
                tgt_rready[w_headIdx] = rsp_ready;
            end
        end
    end

    assign w_push = req_valid && req_ready;
    assign w_pop  = rsp_valid && rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Entry storage needs no reset: occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_errMem[r_wrPtr] <= w_unmapped;
            r_idxMem[r_wrPtr] <= w_sel;
        end
    end

    assign outstanding = r_count;

endmodule

// File: doc/mem_region_router.md
Name: mem_region_router

Overview:
- Routes single-issue data-side memory requests from the load/store path to one of NUM_TARGETS memory targets (local mem, dcache, peripheral bus, ...) by inclusive address range [L, H].
- Generalises the single-range address-config scheme to N prioritised regions.
- Tracks outstanding requests in an in-order FIFO, so responses return in issue order even when targets differ.
- Requests hitting no region are accepted and answered with an error response. This is the source of the LS access-fault path.

Parameters:
- NUM_TARGETS, 4, number of target ports/regions (1..8).
- REGION_L, {32'h80000000, 32'h60000000, 32'h70000000, 32'h00000000}, per-target inclusive lower bound, index 0 first.
- REGION_H, {32'h8FFFFFFF, 32'h6FFFFFFF, 32'h7FFFFFFF, 32'h0000FFFF}, per-target inclusive upper bound.
- MAX_OUTSTANDING, 4, depth of the order FIFO; power of 2, min 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted this cycle when req_valid & req_ready.
- req_addr  in  32  byte address.
- req_we  in  1  1 = write, 0 = read.
- req_wdata  in  32  write data.
- req_be  in  4  byte enables.
- tgt_valid  out  NUM_TARGETS  one-hot request strobe per target.
- tgt_ready  in  NUM_TARGETS  per-target request ready.
- tgt_addr, tgt_we, tgt_wdata, tgt_be  out  32/1/32/4  shared request fields, direct copies of req_*.
- tgt_rvalid  in  NUM_TARGETS  per-target response valid (every request, read or write, yields exactly one response).
- tgt_rdata  in  NUM_TARGETS*32  per-target response data, target i at bits [32i+31:32i].
- tgt_rready  out  NUM_TARGETS  per-target response accept.
- rsp_valid  out  1  response to requester valid.
- rsp_ready  in  1  requester accepts response.
- rsp_data  out  32  response data; 0 for errors and writes are passed through as returned.
- rsp_err  out  1  1 = address matched no region.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  current FIFO occupancy.

Behaviour:
- Region match: hit[i] = (req_addr >= REGION_L[i]) & (req_addr <= REGION_H[i]), compared unsigned. Lowest index wins on overlap; sel = priority-encoded hit. unmapped = ~|hit.
- full = (outstanding == MAX_OUTSTANDING). A push is blocked when full, even if a pop occurs the same cycle; no same-cycle bypass.
- Request path (combinational):
  - tgt_valid[sel] = req_valid & ~full & ~unmapped.
  - req_ready = ~full & (unmapped | tgt_ready[sel]).
  - Unmapped requests never assert any tgt_valid.
- Push on req_valid & req_ready. Each entry = {err = unmapped, idx = sel}. Entries wrap modulo MAX_OUTSTANDING.
- Head entry (when FIFO not empty):
  - err = 0:
    - rsp_valid = tgt_rvalid[idx].
    - tgt_rready[idx] = rsp_ready.
    - All other tgt_rready bits = 0.
    - rsp_data = tgt_rdata[idx].
    - rsp_err = 0.
  - err = 1:
    - rsp_valid = 1.
    - rsp_data = 0.
    - rsp_err = 1.
    - tgt_rready = 0.
- Pop on rsp_valid & rsp_ready.
- Empty: rsp_valid = 0, tgt_rready = 0; any tgt_rvalid is held at the target (stray response, see assertions).
- Latency:
  - Request is forwarded in the same cycle.
  - Earliest response is the cycle after acceptance: an entry becomes head only after its push registers, so a same-cycle tgt_rvalid is not accepted.
  - Error response is earliest the cycle after acceptance, when the entry is head.
- Ordering: a response from a non-head target is stalled (tgt_rready low) until all earlier entries pop. Targets must return their own responses in order.
- Simultaneous push and pop (not full): occupancy unchanged, both pointers advance.
- outstanding: increments on push only, decrements on pop only, unchanged on both or neither. Range 0..MAX_OUTSTANDING.
- Reset (asynchronous, any time including mid-transaction):
  - Pointers and outstanding clear to 0, so FIFO is empty.
  - rsp_valid = 0, tgt_rready = 0, tgt_valid = 0 while rst is high.
  - req_ready = 0 while rst is high, then follows the rules above.
  - In-flight transactions are discarded. Targets must be reset by the same rst.
- Assertions in the bench: tgt_valid is one-hot-or-zero; no tgt_rvalid from a target with no matching outstanding entry.

Test Plan:
- Read 0x80000010, target 0 returns 0xDEADBEEF one cycle later with rsp_ready = 1 -> tgt_valid = 4'b0001 in the request cycle, rsp_valid with rsp_data = 0xDEADBEEF, rsp_err = 0; outstanding goes 0 -> 1 -> 0.
- Read 0x40000000 (unmapped) -> tgt_valid = 0, req_ready = 1; next cycle rsp_valid = 1, rsp_data = 0, rsp_err = 1.
- Ordering: read target 1 (0x60000000), then read target 0 (0x80000000); target 0 responds first with 0x11, target 1 responds 2 cycles later with 0x22 -> rsp_data sequence is 0x22 then 0x11; tgt_rready[0] stays low until target 1's response pops.
- Fill: 4 reads to target 0 with rsp_ready = 0 -> outstanding = 4, req_ready = 0 for a 5th request. Raise rsp_ready together with a pending 5th request -> pop occurs, push blocked that cycle, 5th request accepted the next cycle.
- Overlap and boundary: REGION_L[3] = 0, REGION_H[3] = 0xFFFF.
  - Address 0x0000FFFF -> target 3.
  - Address 0x00010000 -> error.
  - Address 0x6FFFFFFF -> target 1.
  - Address 0x70000000 -> target 2.
- Reset with 3 outstanding entries and a pending target response -> rsp_valid = 0 and outstanding = 0 immediately while rst is high, no pop. After release, a fresh read to 0x80000000 completes normally.
